// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: registered N-channel selector with a one-entry output register.
// Arbitration is round-robin (mode=0) or a fixed channel select (mode=1).
// The winning beat is captured into out_data/out_sel/out_valid.
//
// Optional packet lock is enabled by defining MUXN_LOCK_EN. It adds in_last,
// out_last and a lock_state debug output. Once a channel sends a beat with
// in_last=0, that channel keeps the grant until it sends its in_last=1 beat.
//
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both high at the rising clock edge. A source must hold valid and data
// stable until that transfer happens. in_ready is derived from in_valid, so
// in_valid must never depend on in_ready. out_valid does not depend on
// out_ready.
module muxn_rr_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel,
`ifdef MUXN_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
    output logic [0:0]                lock_state,
`endif
    input  logic                      out_ready
);

`ifdef MUXN_LOCK_EN
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]      lock_state_q, lock_state_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic            out_last_q, out_last_d;
`endif

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic [SELW-1:0]  last_q, last_d;

    logic             load_ok;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    logic             in_fire;
    int               scan_idx;
    logic [SELW-1:0]  scan_sel;

    // The output register can accept a new beat when it is empty or draining.
    assign load_ok = !out_valid_q || out_ready;
    assign in_fire = grant_any && load_ok;

    // Grant selection: lock override, then fixed select, then round-robin from last+1.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        scan_sel  = '0;
`ifdef MUXN_LOCK_EN
        if (lock_state_q == ST_LOCKED) begin
            grant_idx = lock_ch_q;
            grant_any = in_valid[lock_ch_q];
        end else
`endif
        if (mode) begin
            // Out-of-range select grants nothing.
            if (int'(sel) < CHANNELS) begin
                grant_idx = sel;
                grant_any = in_valid[sel];
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                scan_idx = (int'(last_q) + k) % CHANNELS;
                scan_sel = SELW'(scan_idx);
                if (!grant_any && in_valid[scan_sel]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_sel;
                end
            end
        end
    end

    // At most one ready bit: only the granted channel, and only when the register can load.
    always_comb begin
        in_ready = '0;
        if (in_fire) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic for the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_sel_d   = grant_idx;
            // Fixed-select traffic leaves the round-robin history alone.
            if (!mode) begin
                last_d = grant_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUXN_LOCK_EN
    // Packet lock FSM: lock on a non-last beat, release on the last beat.
    always_comb begin
        lock_state_d = lock_state_q;
        lock_ch_d    = lock_ch_q;
        out_last_d   = out_last_q;
        if (in_fire) begin
            out_last_d = in_last[grant_idx];
            if (lock_state_q == ST_UNLOCKED) begin
                if (!in_last[grant_idx]) begin
                    lock_state_d = ST_LOCKED;
                    lock_ch_d    = grant_idx;
                end
            end else if (in_last[grant_idx]) begin
                lock_state_d = ST_UNLOCKED;
            end
        end
    end

    // Lock state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state_q <= ST_UNLOCKED;
            lock_ch_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_ch_q    <= lock_ch_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_last   = out_last_q;
    assign lock_state = lock_state_q;
`endif

    // Output register and pointer; reset puts last at CHANNELS-1 so channel 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_q      <= SELW'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed testbench for muxn_rr_reg (WIDTH=8, CHANNELS=4).
// Inputs change 1 ns after a rising edge. Registered outputs are sampled at
// that same point. in_ready is sampled 1 ns after the inputs change.
module tb_muxn_rr_reg;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SELW     = 2;

    logic                      clk;
    logic                      reset_n;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_ready;
`ifdef MUXN_LOCK_EN
    logic [CHANNELS-1:0]       in_last;
    logic                      out_last;
    logic [0:0]                lock_state;
`endif

    int checks;
    int errors;

    muxn_rr_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef MUXN_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
        .lock_state(lock_state),
`endif
        .out_ready (out_ready)
    );

    // Clock generation: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
`ifdef MUXN_LOCK_EN
        in_last   = '1;
`endif
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d, want v=0 d=00 s=0", out_valid, out_data, out_sel);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 0000", in_ready);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [SELW-1:0]  exp_sel;
        logic [WIDTH-1:0] exp_data;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_sel  = SELW'(i % 4);
            exp_data = 8'h10 + WIDTH'(i % 4);
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_sel)) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b, want %b", i, in_ready, 4'b0001 << exp_sel);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_data) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h, want v=1 s=%0d d=%h",
                         i, out_valid, out_sel, out_data, exp_sel, exp_data);
            end
        end
        // The pointer now sits at channel 0; drain the register.
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_fixed_select();
        mode     = 1'b1;
        sel      = 2'd2;
        in_valid = 4'b1111;
        in_data  = 32'h13A51110;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready: got %b, want 0100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out: got v=%b d=%h s=%0d, want v=1 d=a5 s=2", out_valid, out_data, out_sel);
        end
        // The selected channel goes idle while the others stay valid.
        in_valid = 4'b1011;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL fixed_nogrant_ready: got %b, want 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
            errors++;
            $display("FAIL fixed_drain: got v=%b d=%h s=%0d, want v=0 d=a5 s=2", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_backpressure();
        mode      = 1'b1;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        in_data   = 32'h00003C00;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1) begin
            errors++;
            $display("FAIL bp_load: got v=%b d=%h s=%0d, want v=1 d=3c s=1", out_valid, out_data, out_sel);
        end
        // The next beat waits on channel 1 while downstream stalls.
        in_data   = 32'h00005A00;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall_ready[%0d]: got %b, want 0000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1) begin
                errors++;
                $display("FAIL bp_stall_hold[%0d]: got v=%b d=%h s=%0d, want v=1 d=3c s=1",
                         i, out_valid, out_data, out_sel);
            end
        end
        // Drain and reload in the same cycle.
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, want 0010", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            errors++;
            $display("FAIL bp_reload: got v=%b d=%h, want v=1 d=5a", out_valid, out_data);
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [SELW-1:0] exp_sel;
        // The pointer is at 0, so channel 1 wins first.
        mode      = 1'b0;
        in_valid  = 4'b1010;
        in_data   = 32'h23222120;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_sel = (i % 2 == 0) ? 2'd1 : 2'd3;
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_sel)) begin
                errors++;
                $display("FAIL fair_ready[%0d]: got %b, want %b", i, in_ready, 4'b0001 << exp_sel);
            end
            tick();
            checks++;
            if (out_sel !== exp_sel || out_data !== (8'h20 + WIDTH'(exp_sel))) begin
                errors++;
                $display("FAIL fair_out[%0d]: got s=%0d d=%h, want s=%0d", i, out_sel, out_data, exp_sel);
            end
        end
        // The pointer is now at 1. A fixed burst on channel 0 must leave it alone.
        mode     = 1'b1;
        sel      = 2'd0;
        in_valid = 4'b1011;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_sel !== 2'd0 || out_data !== 8'h20) begin
                errors++;
                $display("FAIL fair_burst[%0d]: got s=%0d d=%h, want s=0 d=20", i, out_sel, out_data);
            end
        end
        mode     = 1'b0;
        in_valid = 4'b1010;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL fair_resume_ready: got %b, want 1000", in_ready);
        end
        tick();
        checks++;
        if (out_sel !== 2'd3) begin
            errors++;
            $display("FAIL fair_resume_out: got s=%0d, want 3", out_sel);
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_async_reset();
        // Load from channel 2 in round-robin so the pointer moves off CHANNELS-1.
        mode      = 1'b0;
        in_valid  = 4'b0100;
        in_data   = 32'h00770000;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || out_sel !== 2'd2) begin
            errors++;
            $display("FAIL areset_pre: got v=%b d=%h s=%0d, want v=1 d=77 s=2", out_valid, out_data, out_sel);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            errors++;
            $display("FAIL areset_immediate: got v=%b d=%h s=%0d, want v=0 d=00 s=0", out_valid, out_data, out_sel);
        end
        @(posedge clk);
        #3 reset_n = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL areset_first_grant: got %b, want 0001", in_ready);
        end
        tick();
        checks++;
        if (out_sel !== 2'd0 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL areset_first_out: got s=%0d d=%h, want s=0 d=10", out_sel, out_data);
        end
        in_valid = '0;
        tick();
    endtask

`ifdef MUXN_LOCK_EN
    task automatic test_lock();
        logic [3:0] last_seq [4];
        logic [1:0] sel_seq  [4];
        logic       olast_seq[4];
        last_seq  = '{4'b1011, 4'b1011, 4'b1111, 4'b1111};
        sel_seq   = '{2'd2, 2'd2, 2'd2, 2'd0};
        olast_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
        // The pointer is at 0, so channel 2 wins first and then holds the lock.
        mode      = 1'b0;
        in_valid  = 4'b0101;
        in_data   = 32'h00C200C0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_last = last_seq[i];
            tick();
            checks++;
            if (out_sel !== sel_seq[i] || out_last !== olast_seq[i]) begin
                errors++;
                $display("FAIL lock_beat[%0d]: got s=%0d last=%b, want s=%0d last=%b",
                         i, out_sel, out_last, sel_seq[i], olast_seq[i]);
            end
        end
        in_valid = '0;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_fixed_select();
        test_backpressure();
        test_fairness();
        test_async_reset();
`ifdef MUXN_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
